// File: rtl/sram_array_ctrl.sv
// Sequencer for a row-addressed mixed-signal SRAM array: precharge/data-setup phase,
// one-hot wordline pulse and sense-amp strobe, one request at a time over ready/req.
module sram_array_ctrl #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned ADDR_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
   parameter int unsigned PRE_CYCLES = 1,
   parameter int unsigned WL_CYCLES  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [COLS-1:0]   wdata,
   output logic              ready,
   output logic              rvalid,
   output logic [COLS-1:0]   rdata,
   output logic              err,
   output logic [ROWS-1:0]   row_wr,
   output logic [ROWS-1:0]   row_rd,
   output logic [COLS-1:0]   data_in,
   output logic              precharge,
   output logic              sa_en,
   input  logic [COLS-1:0]   sa_out
);

   localparam int unsigned MAX_CYC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StWlWr,
      StWlRd,
      StRecover
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic              oor_q;
   logic [COLS-1:0]   data_in_q;
   logic [COLS-1:0]   rdata_q;
   logic [ROWS-1:0]   row_sel;
   logic              accept;
   logic              addr_oor;

   assign accept   = req & ready_q & (state_q == StIdle);
   assign addr_oor = (32'(addr) >= ROWS);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the counter times both the PRE and wordline phases
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StPre;
               cnt_d   = PRE_LOAD;
            end
         end
         StPre: begin
            if (cnt_q == '0) begin
               state_d = we_q ? StWlWr : StWlRd;
               cnt_d   = WL_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StWlWr, StWlRd: begin
            if (cnt_q == '0) begin
               state_d = StRecover;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRecover: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Request latches and data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         oor_q     <= 1'b0;
         data_in_q <= '0;
         rdata_q   <= '0;
      end else begin
         // Registered so ready stays low throughout reset and never follows req directly
         ready_q <= (state_d == StIdle);
         if (accept) begin
            we_q   <= we;
            addr_q <= addr;
            oor_q  <= addr_oor;
            if (we) begin
               data_in_q <= wdata;
            end
         end
         if ((state_q == StWlRd) && (cnt_q == '0)) begin
            rdata_q <= oor_q ? '0 : sa_out;
         end
      end
   end

   // One-hot row decode; an out-of-range address selects no row at all
   always_comb begin
      row_sel = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         row_sel[i] = !oor_q && (addr_q == ADDR_W'(i));
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      row_wr    = '0;
      row_rd    = '0;
      precharge = 1'b0;
      sa_en     = 1'b0;
      rvalid    = 1'b0;
      err       = 1'b0;
      unique case (state_q)
         StPre: begin
            precharge = ~we_q;
         end
         StWlWr: begin
            row_wr = row_sel;
         end
         StWlRd: begin
            row_rd = row_sel;
            sa_en  = (cnt_q == '0);
         end
         StRecover: begin
            rvalid = ~we_q;
            err    = oor_q;
         end
         default: begin
         end
      endcase
   end

   assign ready   = ready_q;
   assign data_in = data_in_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: two instances (4 rows PRE=1/WL=2, 3 rows PRE=3/WL=1) checked
// against a phase-offset reference model, a physical array model and a response scoreboard.
module tb_sram_array_ctrl;

   localparam int unsigned R0 = 4, P0 = 1, W0 = 2;
   localparam int unsigned R1 = 3, P1 = 3, W1 = 1;

   typedef struct {
      int         t;
      logic       is_read;
      logic [3:0] rdata;
      logic       err;
   } resp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1;
   logic       req0, we0, req1, we1;
   logic [1:0] addr0, addr1;
   logic [3:0] wdata0, wdata1;
   logic       ready0, rvalid0, err0, precharge0, sa_en0;
   logic       ready1, rvalid1, err1, precharge1, sa_en1;
   logic [3:0] rdata0, data_in0, sa_out0, row_wr0, row_rd0;
   logic [3:0] rdata1, data_in1, sa_out1;
   logic [2:0] row_wr1, row_rd1;

   sram_array_ctrl #(.ROWS(R0), .COLS(4), .PRE_CYCLES(P0), .WL_CYCLES(W0)) u_dut0 (
      .clk(clk), .rst(rst0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0), .row_wr(row_wr0),
      .row_rd(row_rd0), .data_in(data_in0), .precharge(precharge0), .sa_en(sa_en0),
      .sa_out(sa_out0)
   );

   sram_array_ctrl #(.ROWS(R1), .COLS(4), .PRE_CYCLES(P1), .WL_CYCLES(W1)) u_dut1 (
      .clk(clk), .rst(rst1), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
      .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .err(err1), .row_wr(row_wr1),
      .row_rd(row_rd1), .data_in(data_in1), .precharge(precharge1), .sa_en(sa_en1),
      .sa_out(sa_out1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int nedge = 0;

   logic [3:0] phys [2][4];
   logic [3:0] refm [2][4];
   logic [3:0] junk;

   bit         active [2];
   int         acc_n [2];
   int         acc_cnt [2];
   int         last_acc [2];
   logic       m_we [2];
   logic [1:0] m_addr [2];
   logic [3:0] m_din [2];
   logic [3:0] m_rexp [2];
   logic [3:0] m_rdata [2];
   logic       armed0, armed1;
   resp_t      sb0[$], sb1[$];

   function automatic int rows(input int d);
      return (d == 0) ? R0 : R1;
   endfunction
   function automatic int pre(input int d);
      return (d == 0) ? P0 : P1;
   endfunction
   function automatic int wl(input int d);
      return (d == 0) ? W0 : W1;
   endfunction

   always @(posedge clk) junk <= 4'($urandom);
   always @(posedge clk or posedge rst0) if (rst0) armed0 <= 1'b0; else armed0 <= 1'b1;
   always @(posedge clk or posedge rst1) if (rst1) armed1 <= 1'b0; else armed1 <= 1'b1;

   // Sense amps: a selected row returns its stored bits, otherwise noise
   always_comb begin
      sa_out0 = junk;
      for (int i = 0; i < 4; i++) if (row_rd0[i]) sa_out0 = phys[0][i];
   end
   always_comb begin
      sa_out1 = junk;
      for (int i = 0; i < 3; i++) if (row_rd1[i]) sa_out1 = phys[1][i];
   end

   task automatic chk(input int d, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", d, name, act, exp, $time);
      end
   endtask

   function automatic int sb_size(input int d);
      return (d == 0) ? sb0.size() : sb1.size();
   endfunction
   function automatic resp_t sb_front(input int d);
      return (d == 0) ? sb0[0] : sb1[0];
   endfunction
   task automatic sb_pop(input int d);
      if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
   endtask
   task automatic sb_push(input int d, input resp_t e);
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   task automatic model_step(input int d, input logic r, input logic rq, input logic w,
                             input logic [1:0] a, input logic [3:0] wd, input logic rdy,
                             input logic [3:0] rw, input logic [3:0] rr, input logic [3:0] din,
                             input logic pc, input logic sae, input logic rv, input logic er,
                             input logic [3:0] rd, input logic arm);
      int         tt, off;
      bit         busy, oor, in_pre, in_wl, in_rec;
      logic [3:0] sel;
      resp_t      e;
      tt = pre(d) + wl(d) + 1;
      if (r) begin
         active[d]  = 1'b0;
         m_din[d]   = '0;
         m_rdata[d] = '0;
         if (d == 0) sb0.delete(); else sb1.delete();
         chk(d, "reset ready", rdy, 0);
         chk(d, "reset wordlines", {rw, rr}, 0);
         chk(d, "reset strobes", {pc, sae, rv, er}, 0);
         chk(d, "reset data_in", din, 0);
         chk(d, "reset rdata", rd, 0);
         return;
      end
      for (int i = 0; i < rows(d); i++) if (rw[i]) phys[d][i] = din;
      if (active[d] && (nedge - acc_n[d] > tt)) active[d] = 1'b0;
      busy   = active[d];
      off    = nedge - acc_n[d];
      oor    = (int'(m_addr[d]) >= rows(d));
      in_pre = busy && off <= pre(d);
      in_wl  = busy && off > pre(d) && off <= pre(d) + wl(d);
      in_rec = busy && off == tt;
      sel    = '0;
      if (!oor) sel[m_addr[d]] = 1'b1;
      if (in_rec && !m_we[d]) m_rdata[d] = m_rexp[d];

      chk(d, "ready", rdy, arm && !busy);
      chk(d, "row_wr", rw, (in_wl && m_we[d]) ? sel : 4'b0);
      chk(d, "row_rd", rr, (in_wl && !m_we[d]) ? sel : 4'b0);
      chk(d, "precharge", pc, in_pre && !m_we[d]);
      chk(d, "sa_en", sae, in_wl && !m_we[d] && off == pre(d) + wl(d));
      chk(d, "data_in", din, m_din[d]);
      chk(d, "rdata held", rd, m_rdata[d]);
      chk(d, "inv row_wr onehot0", $onehot0(rw), 1);
      chk(d, "inv row_rd onehot0", $onehot0(rr), 1);
      chk(d, "inv wr/rd exclusive", (rw != 0) && (rr != 0), 0);
      chk(d, "inv precharge vs wl", pc && ((rw | rr) != 0), 0);
      chk(d, "inv sa_en source", sae && (rr == 0) && !(busy && !m_we[d] && oor), 0);

      // Scoreboard: pop on every presented response, flag overdue ones
      if (rv || er) begin
         if (sb_size(d) == 0) begin
            chk(d, "unexpected rvalid/err", {rv, er}, 2'b00);
         end else begin
            e = sb_front(d);
            sb_pop(d);
            chk(d, "resp cycle", nedge, e.t);
            chk(d, "resp rvalid", rv, e.is_read);
            chk(d, "resp err", er, e.err);
            if (e.is_read) chk(d, "resp rdata", rd, e.rdata);
         end
      end else if (sb_size(d) != 0) begin
         e = sb_front(d);
         if (e.t < nedge) begin
            chk(d, "resp missing, cycle", nedge, e.t);
            sb_pop(d);
         end
      end

      if (arm && !busy && rq) begin
         active[d]   = 1'b1;
         acc_n[d]    = nedge;
         last_acc[d] = nedge;
         acc_cnt[d]++;
         m_we[d]     = w;
         m_addr[d]   = a;
         oor         = (int'(a) >= rows(d));
         if (w) begin
            m_din[d] = wd;
            if (!oor) refm[d][a] = wd;
         end
         m_rexp[d] = (!w && !oor) ? refm[d][a] : 4'b0;
         if (!w || oor) begin
            e.t = nedge + tt; e.is_read = !w; e.rdata = m_rexp[d]; e.err = oor;
            sb_push(d, e);
         end
      end
   endtask

   always @(negedge clk) begin
      nedge++;
      model_step(0, rst0, req0, we0, addr0, wdata0, ready0, row_wr0, row_rd0, data_in0,
                 precharge0, sa_en0, rvalid0, err0, rdata0, armed0);
      model_step(1, rst1, req1, we1, addr1, wdata1, ready1, {1'b0, row_wr1}, {1'b0, row_rd1},
                 data_in1, precharge1, sa_en1, rvalid1, err1, rdata1, armed1);
   end

   task automatic set_in(input int d, input logic r, input logic w, input logic [1:0] a,
                         input logic [3:0] wd);
      if (d == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = wd; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = wd; end
   endtask

   // Raise req until accepted; optionally drop it, optionally wiggle inputs while busy
   task automatic issue(input int d, input logic w, input logic [1:0] a, input logic [3:0] wd,
                        input bit drop, input bit noise);
      int c0;
      bit got;
      c0  = acc_cnt[d];
      got = 1'b0;
      @(posedge clk);
      #1 set_in(d, 1'b1, w, a, wd);
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         if (acc_cnt[d] != c0) got = 1'b1;
      end
      if (!got) begin
         chk(d, "accept timeout", acc_cnt[d], c0 + 1);
         #1 set_in(d, 1'b0, 1'b0, 2'b0, 4'b0);
         return;
      end
      if (noise) begin
         for (int i = 0; i < pre(d) + wl(d) + 1; i++) begin
            #1 set_in(d, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
            @(posedge clk);
         end
      end
      if (drop || noise) #1 set_in(d, 1'b0, 1'b0, 2'b0, 4'b0);
   endtask

   initial begin
      int a1;
      rst0 = 1'b1; rst1 = 1'b1;
      set_in(0, 1'b0, 1'b0, 2'b0, 4'b0);
      set_in(1, 1'b0, 1'b0, 2'b0, 4'b0);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            phys[d][i] = 4'($urandom);
            refm[d][i] = phys[d][i];
         end
      end
      repeat (3) @(posedge clk);
      #1 rst0 = 1'b0; rst1 = 1'b0;
      repeat (2) @(posedge clk);

      // Write then read row 2
      issue(0, 1'b1, 2'd2, 4'hA, 1'b1, 1'b0);
      issue(0, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0);

      // Back-to-back writes with req held high
      issue(0, 1'b1, 2'd0, 4'h5, 1'b0, 1'b0);
      a1 = last_acc[0];
      issue(0, 1'b1, 2'd3, 4'h5, 1'b1, 1'b0);
      chk(0, "back-to-back spacing", last_acc[0] - a1, P0 + W0 + 2);
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 2'(i), 4'h0, 1'b1, 1'b0);

      // Reset in the middle of the wordline phase of a read
      issue(0, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0);
      @(posedge clk);
      #2 chk(0, "row_rd before reset", row_rd0, 4'b0100);
      rst0 = 1'b1;
      #1 chk(0, "row_rd after async reset", row_rd0, 4'b0000);
      chk(0, "strobes after async reset", {sa_en0, rvalid0, err0, ready0}, 4'b0000);
      repeat (2) @(posedge clk);
      #1 rst0 = 1'b0;
      issue(0, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0);

      // req wiggling while busy must be ignored
      issue(0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b1);
      issue(0, 1'b1, 2'd1, 4'h3, 1'b1, 1'b1);
      issue(0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0);

      // Out-of-range and long-precharge instance
      issue(1, 1'b0, 2'd3, 4'h0, 1'b1, 1'b0);
      issue(1, 1'b1, 2'd3, 4'hF, 1'b1, 1'b0);
      issue(1, 1'b1, 2'd1, 4'h9, 1'b1, 1'b0);
      issue(1, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0);

      // Random traffic on both instances
      for (int n = 0; n < 40; n++) begin
         int d;
         d = int'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         issue(d, 1'($urandom), 2'($urandom), 4'($urandom), 1'b1, 1'($urandom));
      end

      repeat (15) @(posedge clk);
      @(negedge clk);
      #1;
      chk(0, "responses outstanding", sb0.size(), 0);
      chk(1, "responses outstanding", sb1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
